// File: rtl/sr_cmd_gen_if.sv
// sr_cmd_gen_if: request/command bundle between a requester and sr_cmd_gen.
//   set_raw / reset_raw : raw, possibly bouncy request lines into the generator
//   s / r               : clean one-cycle command pulses towards the sr stage
//   busy / drop         : generator status
//   conflict_cnt        : present only when SR_CONFLICT_CNT_EN is defined
// master modport: the requester side. slave modport: the generator itself.

interface sr_cmd_gen_if;
  logic       set_raw;
  logic       reset_raw;
  logic       s;
  logic       r;
  logic       busy;
  logic       drop;
`ifdef SR_CONFLICT_CNT_EN
  logic [7:0] conflict_cnt;

  modport master (
    output set_raw,
    output reset_raw,
    input  s,
    input  r,
    input  busy,
    input  drop,
    input  conflict_cnt
  );

  modport slave (
    input  set_raw,
    input  reset_raw,
    output s,
    output r,
    output busy,
    output drop,
    output conflict_cnt
  );
`else
  modport master (
    output set_raw,
    output reset_raw,
    input  s,
    input  r,
    input  busy,
    input  drop
  );

  modport slave (
    input  set_raw,
    input  reset_raw,
    output s,
    output r,
    output busy,
    output drop
  );
`endif
endinterface : sr_cmd_gen_if

// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen: command stage in front of an sr flip-flop.
// Two raw request lines are synchronised, debounced and edge-detected; a small
// FSM turns each accepted rising edge into a single registered s or r pulse,
// never both, followed by a hold-off window in which new requests are dropped.
// Optional feature macro: SR_CONFLICT_CNT_EN adds a saturating 8-bit count of
// simultaneous set+reset requests seen while idle (port bus.conflict_cnt).

module sr_cmd_gen #(
  parameter int DEBOUNCE_CYCLES = 4,  // cycles a changed level must persist (>=1)
  parameter int HOLDOFF_CYCLES  = 3,  // idle cycles after each pulse (>=1)
  parameter int CNT_W           = 4,  // must hold max(DEBOUNCE_CYCLES, HOLDOFF_CYCLES)
  parameter int RESET_PRIORITY  = 1   // 1: set+reset together issues r, 0: issues s
) (
  input  logic         clk,
  input  logic         rst,
  sr_cmd_gen_if.slave  bus
);

  // Terminal counts for the debounce and hold-off counters.
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Channel 0 carries the set request, channel 1 the reset request.
  localparam int CH_SET = 0;
  localparam int CH_RST = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE   = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  logic [1:0]       raw;
  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic [1:0]       stable;
  logic [1:0]       stable_d;
  logic             req_s;
  logic             req_r;
  logic             req_any;
  logic             req_both;

  state_t           state;
  logic [CNT_W-1:0] hold_cnt;
  logic             s_q;
  logic             r_q;
  logic             busy_q;
  logic             drop_q;

  assign raw = {bus.reset_raw, bus.set_raw};

  // Two-flop synchroniser per channel; sync1 feeds nothing but sync2.
  always_ff @(posedge clk) begin
    // NOTE: every register here is written with <= so all flops sample the
    // pre-edge values together; blocking = would collapse the two stages.
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // One debouncer per channel. The stable level only moves after the
  // synchronised input has disagreed with it for DEBOUNCE_CYCLES edges in a
  // row; a single agreeing sample restarts the count.
  for (genvar ch = 0; ch < 2; ch++) begin : g_db
    logic             stable_q;
    logic [CNT_W-1:0] db_cnt;

    // Run-length counter of consecutive disagreeing samples.
    always_ff @(posedge clk) begin
      if (rst) begin
        stable_q <= 1'b0;
        db_cnt   <= '0;
      end else if (sync2[ch] != stable_q) begin
        if (db_cnt == DB_LAST) begin
          stable_q <= sync2[ch];
          db_cnt   <= '0;
        end else begin
          db_cnt <= db_cnt + CNT_ONE;
        end
      end else begin
        db_cnt <= '0;
      end
    end

    assign stable[ch] = stable_q;
  end

  // Previous stable level, used to find rising edges of the debounced lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_d <= '0;
    end else begin
      stable_d <= stable;
    end
  end

  // A request is a rising edge of the debounced level; falling edges are ignored.
  assign req_s    = stable[CH_SET] & ~stable_d[CH_SET];
  assign req_r    = stable[CH_RST] & ~stable_d[CH_RST];
  assign req_any  = req_s | req_r;
  assign req_both = req_s & req_r;

  // Command FSM with registered s, r, busy and drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
      s_q      <= 1'b0;
      r_q      <= 1'b0;
      busy_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      // NOTE: pulse outputs get a default of 0 at the top of every clocked
      // cycle, so each one stays high for exactly one cycle unless re-set below.
      s_q    <= 1'b0;
      r_q    <= 1'b0;
      drop_q <= 1'b0;

      case (state)
        IDLE: begin
          if (req_any) begin
            state  <= PULSE;
            busy_q <= 1'b1;
            if (req_both) begin
              // Only one command may reach the sr stage; the loser is reported.
              drop_q <= 1'b1;
              if (RESET_PRIORITY != 0) begin
                r_q <= 1'b1;
              end else begin
                s_q <= 1'b1;
              end
            end else if (req_s) begin
              s_q <= 1'b1;
            end else begin
              r_q <= 1'b1;
            end
          end
        end

        PULSE: begin
          state    <= HOLDOFF;
          hold_cnt <= '0;
          if (req_any) begin
            drop_q <= 1'b1;
          end
        end

        HOLDOFF: begin
          if (hold_cnt == HOLD_LAST) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + CNT_ONE;
          end
          if (req_any) begin
            drop_q <= 1'b1;
          end
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s    = s_q;
  assign bus.r    = r_q;
  assign bus.busy = busy_q;
  assign bus.drop = drop_q;

`ifdef SR_CONFLICT_CNT_EN
  logic [7:0] conflict_q;

  // Saturating count of simultaneous requests that reached the idle FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_q <= '0;
    end else if ((state == IDLE) && req_both && (conflict_q != 8'hFF)) begin
      conflict_q <= conflict_q + 8'd1;
    end
  end

  assign bus.conflict_cnt = conflict_q;
`endif

endmodule : sr_cmd_gen
